led_matrix_scanner: RTL and testbench
=====================================

Name: led_matrix_scanner

Overview:
- Parametrised column-scan driver for a ROWS x COLS LED dot matrix.
- Holds a MSG_COLS-wide pattern memory and drives one column at a time, active-low, with its row pattern.
- Supports static, scroll-left, scroll-right and blank modes.
- Replaces the fixed 5x7 hard-wired register/counter/divider arrangement in the display path; the clock prescaling is internal.

Parameters:
- ROWS, 5, LEDs per column (row_data width).
- COLS, 7, physical columns scanned (COLS >= 2).
- MSG_COLS, 16, pattern memory depth in columns (>= 1).
- SCAN_DIV, 1000, clk cycles per column slot (>= 2).
- SCROLL_DIV, 64, complete frames per scroll step (>= 1).
- AW, derived, max(1, ceil(log2(MSG_COLS))).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset; synchronous, active-high.
- mode  input  2  00 static, 01 scroll left, 10 scroll right, 11 blank.
- wr_en  input  1  pattern memory write strobe.
- wr_addr  input  AW  write column address.
- wr_data  input  ROWS  column pattern; bit r = row r lit.
- col_n  output  COLS  column enables, active-low one-hot; bit c = column c.
- row_data  output  ROWS  row pattern for the enabled column.
- frame_start  output  1  one-cycle pulse when column 0 is selected.
- offset  output  AW  current scroll offset.

Behaviour:
- Prescaler scan_cnt counts 0..SCAN_DIV-1 and wraps; tick = (scan_cnt == SCAN_DIV-1).
- On tick, col_idx advances 0..COLS-1 and wraps.
- Each wrap COLS-1 -> 0 is a frame end; frame_cnt counts 0..SCROLL_DIV-1 and wraps on frame ends.
- Scroll step occurs on a frame end with frame_cnt == SCROLL_DIV-1:
  - mode 01: offset = (offset+1) mod MSG_COLS.
  - mode 10: offset = (offset-1) mod MSG_COLS; 0 -> MSG_COLS-1.
  - mode 00/11: offset held.
  - frame_cnt keeps counting in all modes.
- Mode changes take effect on the next cycle; offset is never reset by a mode change.
- Displayed address = (offset + col_idx) mod MSG_COLS. Correct for MSG_COLS < COLS: pattern repeats.
- Outputs are registered, 1-cycle latency from the col_idx/offset update:
  - col_n = all ones except bit col_idx = 0.
  - row_data = mem[displayed address].
  - Mode 11 forces col_n all ones and row_data 0; scanning and counters continue.
- frame_start is registered and asserted in the same cycle col_n first shows column 0 of a frame.
- Memory is MSG_COLS x ROWS flops.
  - Write when wr_en; wr_addr >= MSG_COLS is ignored.
  - A write to the displayed address appears on row_data the cycle after the write.
- Reset values:
  - col_n all ones, row_data 0, frame_start 0, offset 0.
  - scan_cnt, col_idx, frame_cnt 0; memory all 0.
  - First cycle after rst deasserts: col_n = column 0 enabled, frame_start = 1.
- rst mid-frame aborts the scan immediately and restarts from column 0 as above.

Optional Feature:
- Macro: LED_MATRIX_DIM_EN.
- Defined:
  - Adds input port duty [3:0] and a free-running 4-bit pwm_cnt, reset 0, incrementing every clk.
  - row_data is gated to 0 unless (pwm_cnt < duty) or (duty == 15); col_n is unaffected.
  - Result: duty 0 is dark, duty 15 is full on.
- Undefined: no duty port, no pwm_cnt, rows always ungated.

Decomposition:
- Package led_matrix_pkg:
  - mode localparams MODE_STATIC=2'b00, MODE_SCROLL_L=2'b01, MODE_SCROLL_R=2'b10, MODE_BLANK=2'b11.
  - AW computation function.
- Sub-module scan_prescaler:
  - Parameter DIV; ports clk, rst, tick.
  - Instantiated once, for the column slot.

Test Plan:
All scenarios use ROWS=5, COLS=7, MSG_COLS=12, SCAN_DIV=4, SCROLL_DIV=2.
1. Hold rst 3 cycles -> col_n=7'h7F, row_data=0, offset=0. Release -> next cycle col_n=7'b1111110 and frame_start=1. col_n shifts every 4 cycles; frame_start repeats every 28 cycles.
2. Write mem[a]=a+1 for a=0..11, mode 00 -> column c shows row_data=c+1. Repeat with wr_addr=13, data 5'h1F -> no memory change.
3. Mode 01 -> offset=1 after 56 cycles (2 frames); column 0 shows 2, column 6 shows 8. Continue -> offset 11 -> 0; column 1 then shows mem[1]=2.
4. Mode 10 from offset 0 -> after 2 frames offset=11; column 0 shows 12, column 1 shows 1.
5. Mode 11 mid-frame -> next cycle col_n=7'h7F and row_data=0; offset held across 4 frames. Return to 00 -> output resumes at the current col_idx.
6. Assert rst at col_idx 4, offset 5 -> all outputs and memory at reset values. With LED_MATRIX_DIM_EN and duty=4 -> row_data nonzero exactly 4 of every 16 cycles.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared mode encodings and width helper for the LED matrix scanner.
package led_matrix_pkg;

  localparam logic [1:0] MODE_STATIC   = 2'b00;
  localparam logic [1:0] MODE_SCROLL_L = 2'b01;
  localparam logic [1:0] MODE_SCROLL_R = 2'b10;
  localparam logic [1:0] MODE_BLANK    = 2'b11;

  // Counter/address width for a range of n values, never narrower than 1 bit.
  function automatic int calcAw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divide-by-DIV counter; tick is high in the last cycle of each period.
module scan_prescaler #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == CW'(DIV - 1));

endmodule

// File: rtl/led_matrix_scanner.sv
// Column-scan driver for a ROWS x COLS LED matrix with a scrollable MSG_COLS pattern memory.
// Define LED_MATRIX_DIM_EN to add the 4-bit duty input for PWM row dimming.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter  int ROWS       = 5,
  parameter  int COLS       = 7,
  parameter  int MSG_COLS   = 16,
  parameter  int SCAN_DIV   = 1000,
  parameter  int SCROLL_DIV = 64,
  localparam int AW         = calcAw(MSG_COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [ROWS-1:0] wr_data,
`ifdef LED_MATRIX_DIM_EN
  input  logic [3:0]      duty,
`endif
  output logic [COLS-1:0] col_n,
  output logic [ROWS-1:0] row_data,
  output logic            frame_start,
  output logic [AW-1:0]   offset
);

  localparam int CW = calcAw(COLS);
  localparam int FW = calcAw(SCROLL_DIV);

  logic            w_tick;
  logic            w_frameEnd;
  logic            w_scrollStep;
  logic            w_wrValid;
  logic            w_rowOn;
  logic [AW-1:0]   w_dispAddr;
  logic [ROWS-1:0] w_rowRaw;

  logic            r_slotFirst;
  logic [CW-1:0]   r_colIdx;
  logic [FW-1:0]   r_frameCnt;
  logic [AW-1:0]   r_offset;
  logic [ROWS-1:0] r_mem [MSG_COLS];

  scan_prescaler #(.DIV(SCAN_DIV)) u_slotDiv (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_frameEnd   = w_tick && (r_colIdx == CW'(COLS - 1));
  assign w_scrollStep = w_frameEnd && (r_frameCnt == FW'(SCROLL_DIV - 1));
  assign w_wrValid    = wr_en && (32'(wr_addr) < 32'(MSG_COLS));
  assign offset       = r_offset;

  always_comb begin
    w_dispAddr = AW'((32'(r_offset) + 32'(r_colIdx)) % 32'(MSG_COLS));
  end

  // A write landing on the displayed column is forwarded so it shows without an extra cycle.
  assign w_rowRaw = (w_wrValid && (wr_addr == w_dispAddr)) ? wr_data : r_mem[w_dispAddr];

`ifdef LED_MATRIX_DIM_EN
  logic [3:0] r_pwmCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwmCnt <= '0;
    end else begin
      r_pwmCnt <= r_pwmCnt + 1'b1;
    end
  end

  assign w_rowOn = (r_pwmCnt < duty) || (duty == 4'hF);
`else
  assign w_rowOn = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slotFirst <= 1'b1;
      r_colIdx    <= '0;
      r_frameCnt  <= '0;
      r_offset    <= '0;
    end else begin
      r_slotFirst <= w_tick;
      if (w_tick) begin
        r_colIdx <= (r_colIdx == CW'(COLS - 1)) ? '0 : r_colIdx + 1'b1;
      end
      if (w_frameEnd) begin
        r_frameCnt <= (r_frameCnt == FW'(SCROLL_DIV - 1)) ? '0 : r_frameCnt + 1'b1;
      end
      if (w_scrollStep && mode == MODE_SCROLL_L) begin
        r_offset <= (r_offset == AW'(MSG_COLS - 1)) ? '0 : r_offset + 1'b1;
      end else if (w_scrollStep && mode == MODE_SCROLL_R) begin
        r_offset <= (r_offset == '0) ? AW'(MSG_COLS - 1) : r_offset - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_COLS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wrValid) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Blank mode only masks the drivers; the scan position keeps advancing underneath.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_n       <= '1;
      row_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= r_slotFirst && (r_colIdx == '0);
      if (mode == MODE_BLANK) begin
        col_n    <= '1;
        row_data <= '0;
      end else begin
        col_n    <= ~(COLS'(1) << r_colIdx);
        row_data <= w_rowOn ? w_rowRaw : '0;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner against a cycle-count based reference model.
// Also covers the LED_MATRIX_DIM_EN build when that macro is defined.
module tb_led_matrix_scanner;
  import led_matrix_pkg::*;

  localparam int ROWS       = 5;
  localparam int COLS       = 7;
  localparam int MSG_COLS   = 12;
  localparam int SCAN_DIV   = 4;
  localparam int SCROLL_DIV = 2;
  localparam int AW         = calcAw(MSG_COLS);
  localparam int FRAME_CYC  = SCAN_DIV * COLS;
  localparam int STEP_CYC   = FRAME_CYC * SCROLL_DIV;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      mode = 2'b00;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [ROWS-1:0] wr_data = '0;
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_data;
  logic            frame_start;
  logic [AW-1:0]   offset;
`ifdef LED_MATRIX_DIM_EN
  logic [3:0]      duty = 4'hF;
`endif

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .MSG_COLS(MSG_COLS), .SCAN_DIV(SCAN_DIV), .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
`ifdef LED_MATRIX_DIM_EN
    .duty        (duty),
`endif
    .col_n       (col_n),
    .row_data    (row_data),
    .frame_start (frame_start),
    .offset      (offset)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;

  // Reference state: cycles since reset release, scroll offset and memory image.
  int              k = 0;
  int              mOff = 0;
  logic [ROWS-1:0] mMem [MSG_COLS];
  logic [COLS-1:0] expColN = '1;
  logic [ROWS-1:0] expRow = '0;
  logic            expFs = 1'b0;
  logic [AW-1:0]   expOff = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs follow from position k: column = (k/SCAN_DIV) mod COLS, scroll every STEP_CYC cycles.
  task automatic advanceModel();
    int col;
    int addr;
    if (rst) begin
      k = 0;
      mOff = 0;
      for (int i = 0; i < MSG_COLS; i++) mMem[i] = '0;
      expColN = '1;
      expRow  = '0;
      expFs   = 1'b0;
      expOff  = '0;
    end else begin
      if (wr_en && int'(wr_addr) < MSG_COLS) mMem[int'(wr_addr)] = wr_data;
      col   = (k / SCAN_DIV) % COLS;
      addr  = (mOff + col) % MSG_COLS;
      expFs = ((k % FRAME_CYC) == 0);
      if (mode == 2'b11) begin
        expColN = '1;
        expRow  = '0;
      end else begin
        expColN = ~(COLS'(1) << col);
        expRow  = mMem[addr];
`ifdef LED_MATRIX_DIM_EN
        if (!(((k % 16) < int'(duty)) || duty == 4'hF)) expRow = '0;
`endif
      end
      if (((k + 1) % STEP_CYC) == 0) begin
        if (mode == 2'b01) mOff = (mOff + 1) % MSG_COLS;
        else if (mode == 2'b10) mOff = (mOff + MSG_COLS - 1) % MSG_COLS;
      end
      expOff = AW'(mOff);
      k++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    advanceModel();
    @(negedge clk);
    checkOutput("col_n", 32'(col_n), 32'(expColN));
    checkOutput("row_data", 32'(row_data), 32'(expRow));
    checkOutput("frame_start", 32'(frame_start), 32'(expFs));
    checkOutput("offset", 32'(offset), 32'(expOff));
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] m, input logic we,
                               input logic [AW-1:0] a, input logic [ROWS-1:0] d);
    rst = r;
    mode = m;
    wr_en = we;
    wr_addr = a;
    wr_data = d;
    cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, mode, 1'b0, '0, '0);
  endtask

  task automatic waitCol(input int c, input int budget);
    int n = 0;
    while (col_n !== ~(COLS'(1) << c) && n < budget) begin
      idle(1);
      n++;
    end
    if (col_n !== ~(COLS'(1) << c)) begin
      nVec++;
      nMis++;
      $display("[TB] FAIL waitCol%0d: col_n %0h, column never selected within %0d cycles", c, col_n, budget);
    end
  endtask

  task automatic waitOffset(input int target, input int budget);
    int n = 0;
    while (int'(offset) != target && n < budget) begin
      idle(1);
      n++;
    end
    checkOutput("waitOffset", 32'(offset), 32'(target));
  endtask

  initial begin
    int cnt;
    repeat (3) applyStimulus(1'b1, 2'b00, 1'b0, '0, '0);
    checkOutput("reset col_n", 32'(col_n), 32'h7F);
    checkOutput("reset row_data", 32'(row_data), 32'h0);
    checkOutput("reset offset", 32'(offset), 32'h0);

    applyStimulus(1'b0, 2'b00, 1'b0, '0, '0);
    checkOutput("release col_n", 32'(col_n), 32'h7E);
    checkOutput("release frame_start", 32'(frame_start), 32'h1);

    for (int a = 0; a < MSG_COLS; a++) applyStimulus(1'b0, 2'b00, 1'b1, AW'(a), ROWS'(a + 1));
    applyStimulus(1'b0, 2'b00, 1'b1, AW'(13), 5'h1F);
    waitCol(3, FRAME_CYC + 4);
    checkOutput("static col3", 32'(row_data), 32'd4);
    waitCol(5, FRAME_CYC + 4);
    checkOutput("static col5", 32'(row_data), 32'd6);

`ifdef LED_MATRIX_DIM_EN
    duty = 4'd4;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      idle(1);
      if (row_data != '0) cnt++;
    end
    checkOutput("dim duty4 lit cycles", 32'(cnt), 32'd4);
    duty = 4'hF;
`endif

    mode = 2'b01;
    waitOffset(1, STEP_CYC + 4);
    waitCol(0, FRAME_CYC + 4);
    checkOutput("scrollL col0", 32'(row_data), 32'd2);
    waitCol(6, FRAME_CYC + 4);
    checkOutput("scrollL col6", 32'(row_data), 32'd8);
    waitOffset(0, MSG_COLS * STEP_CYC + 4);
    waitCol(1, FRAME_CYC + 4);
    checkOutput("scrollL wrap col1", 32'(row_data), 32'd2);

    mode = 2'b10;
    waitOffset(11, STEP_CYC + 4);
    waitCol(0, FRAME_CYC + 4);
    checkOutput("scrollR col0", 32'(row_data), 32'd12);
    waitCol(1, FRAME_CYC + 4);
    checkOutput("scrollR col1", 32'(row_data), 32'd1);

    idle(5);
    mode = 2'b11;
    idle(1);
    checkOutput("blank col_n", 32'(col_n), 32'h7F);
    checkOutput("blank row_data", 32'(row_data), 32'h0);
    idle(4 * FRAME_CYC);
    checkOutput("blank offset held", 32'(offset), 32'd11);
    mode = 2'b00;
    idle(FRAME_CYC);

    waitCol(4, FRAME_CYC + 4);
    applyStimulus(1'b1, 2'b00, 1'b0, '0, '0);
    checkOutput("midrst col_n", 32'(col_n), 32'h7F);
    checkOutput("midrst offset", 32'(offset), 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b0, '0, '0);
    checkOutput("midrst restart col_n", 32'(col_n), 32'h7E);
    waitCol(3, FRAME_CYC + 4);
    checkOutput("midrst mem cleared", 32'(row_data), 32'h0);

    // Random traffic: writes in and out of range, mode hopping, rare resets.
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] m;
      m = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 3)) : mode;
`ifdef LED_MATRIX_DIM_EN
      if ($urandom_range(0, 99) == 0) duty = 4'($urandom_range(0, 15));
`endif
      applyStimulus($urandom_range(0, 299) == 0, m, $urandom_range(0, 2) == 0,
                    AW'($urandom_range(0, 15)), ROWS'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
